id_ex_pipe_reg: RTL and testbench

- Decode-to-execute pipeline register of the 5-stage RISC-V core.
- Captures the control word produced by the decode-stage control unit together with decode-stage datapath values, and presents them to the execute stage one cycle later.
- Supports hazard-driven stall (hold) and flush (bubble insertion).
- Generates the execute-stage PC-select and keeps a saturating count of inserted bubbles for debug.

---
 rtl/id_ex_pipe_reg.sv | 155 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall/flush, PC-select generation and a
// saturating bubble counter for debug.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic [2:0]        ALUControlD,
    input  logic              ALUSrcD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [RA_W-1:0]   Rs1D,
    input  logic [RA_W-1:0]   Rs2D,
    input  logic [RA_W-1:0]   RdD,
    input  logic              ZeroE,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic              ALUSrcE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [RA_W-1:0]   Rs1E,
    output logic [RA_W-1:0]   Rs2E,
    output logic [RA_W-1:0]   RdE,
    output logic              PCSrcE,
    output logic [BCNT_W-1:0] BubbleCnt
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } data_t;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d, ctrl_in;
    data_t             data_q, data_d, data_in;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    always_comb begin
        ctrl_in = '{
            reg_write:   RegWriteD,
            result_src:  ResultSrcD,
            mem_write:   MemWriteD,
            jump:        JumpD,
            branch:      BranchD,
            alu_control: ALUControlD,
            alu_src:     ALUSrcD
        };
        data_in = '{
            rd1:      RD1D,
            rd2:      RD2D,
            pc:       PCD,
            pc_plus4: PCPlus4D,
            imm:      ImmExtD,
            rs1:      Rs1D,
            rs2:      Rs2D,
            rd:       RdD
        };
    end

    // Flush beats stall; an invalid decode slot never carries live control into E.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (FlushE) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
        end else if (!StallE) begin
            valid_d = ValidD;
            ctrl_d  = ValidD ? ctrl_in : '0;
            data_d  = data_in;
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (FlushE && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        ValidE      = valid_q;
        RegWriteE   = ctrl_q.reg_write;
        ResultSrcE  = ctrl_q.result_src;
        MemWriteE   = ctrl_q.mem_write;
        JumpE       = ctrl_q.jump;
        BranchE     = ctrl_q.branch;
        ALUControlE = ctrl_q.alu_control;
        ALUSrcE     = ctrl_q.alu_src;
        RD1E        = data_q.rd1;
        RD2E        = data_q.rd2;
        PCE         = data_q.pc;
        PCPlus4E    = data_q.pc_plus4;
        ImmExtE     = data_q.imm;
        Rs1E        = data_q.rs1;
        Rs2E        = data_q.rs2;
        RdE         = data_q.rd;
        PCSrcE      = valid_q & ((ctrl_q.branch & ZeroE) | ctrl_q.jump);
        BubbleCnt   = bcnt_q;
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus randomized stall/flush traffic,
// checked against a field-level model of the E-stage register.
module tb_id_ex_pipe_reg;

    localparam int unsigned BCNT_W = 4;
    localparam int          BMAX   = (1 << BCNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ZeroE;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, PCSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [BCNT_W-1:0] BubbleCnt;

    id_ex_pipe_reg #(.XLEN(32), .RA_W(5), .BCNT_W(BCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .PCSrcE(PCSrcE), .BubbleCnt(BubbleCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, rw;
        logic [1:0]  rsrc;
        logic        mw, j, b;
        logic [2:0]  alu;
        logic        asrc;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t m;
    int   bexp;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic pcsrc_exp;
        pcsrc_exp = m.valid & ((m.b & ZeroE) | m.j);
        chk({tag, ".ValidE"},      32'(ValidE),      32'(m.valid));
        chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(m.rw));
        chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(m.rsrc));
        chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(m.mw));
        chk({tag, ".JumpE"},       32'(JumpE),       32'(m.j));
        chk({tag, ".BranchE"},     32'(BranchE),     32'(m.b));
        chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(m.alu));
        chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(m.asrc));
        chk({tag, ".RD1E"},        RD1E,             m.rd1);
        chk({tag, ".RD2E"},        RD2E,             m.rd2);
        chk({tag, ".PCE"},         PCE,              m.pc);
        chk({tag, ".PCPlus4E"},    PCPlus4E,         m.pc4);
        chk({tag, ".ImmExtE"},     ImmExtE,          m.imm);
        chk({tag, ".Rs1E"},        32'(Rs1E),        32'(m.rs1));
        chk({tag, ".Rs2E"},        32'(Rs2E),        32'(m.rs2));
        chk({tag, ".RdE"},         32'(RdE),         32'(m.rd));
        chk({tag, ".PCSrcE"},      32'(PCSrcE),      32'(pcsrc_exp));
        chk({tag, ".BubbleCnt"},   32'(BubbleCnt),   32'(bexp));
    endtask

    task automatic rand_d();
        ValidD      = 1'($urandom);
        RegWriteD   = 1'($urandom);
        ResultSrcD  = 2'($urandom_range(0, 2));
        MemWriteD   = 1'($urandom);
        JumpD       = 1'($urandom);
        BranchD     = 1'($urandom);
        ALUControlD = 3'($urandom);
        ALUSrcD     = 1'($urandom);
        RD1D        = $urandom;
        RD2D        = $urandom;
        PCD         = $urandom & 32'hFFFF_FFFC;
        PCPlus4D    = PCD + 32'd4;
        ImmExtD     = $urandom;
        Rs1D        = 5'($urandom);
        Rs2D        = 5'($urandom);
        RdD         = 5'($urandom);
    endtask

    task automatic clear_ctrl_d();
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
        ALUControlD = 0; ALUSrcD = 0;
    endtask

    // Apply one clock edge with the given hazard controls and advance the model.
    task automatic step(input logic st, input logic fl, input string tag);
        StallE = st;
        FlushE = fl;
        @(posedge clk);
        if (fl) begin
            m = '0;
            if (bexp < BMAX) bexp++;
        end else if (!st) begin
            m.valid = ValidD;
            m.rw    = ValidD ? RegWriteD   : 1'b0;
            m.rsrc  = ValidD ? ResultSrcD  : 2'b0;
            m.mw    = ValidD ? MemWriteD   : 1'b0;
            m.j     = ValidD ? JumpD       : 1'b0;
            m.b     = ValidD ? BranchD     : 1'b0;
            m.alu   = ValidD ? ALUControlD : 3'b0;
            m.asrc  = ValidD ? ALUSrcD     : 1'b0;
            m.rd1 = RD1D; m.rd2 = RD2D; m.pc = PCD; m.pc4 = PCPlus4D; m.imm = ImmExtD;
            m.rs1 = Rs1D; m.rs2 = Rs2D; m.rd = RdD;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        m = '0;
        bexp = 0;
        rst_n = 1'b0;
        StallE = 0; FlushE = 0; ZeroE = 0;
        rand_d();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First post-reset load.
        rand_d();
        RdD = 5'd5; ImmExtD = 32'hFFFF_FFF0;
        step(0, 0, "first_load");
        chk("first_load.RdE5", 32'(RdE), 32'd5);

        // add-class then sw-class word, one edge apart.
        clear_ctrl_d();
        ValidD = 1; RegWriteD = 1; ALUControlD = 3'b000; ResultSrcD = 2'b00;
        step(0, 0, "add");
        chk("add.RegWriteE", 32'(RegWriteE), 32'd1);
        clear_ctrl_d();
        ValidD = 1; MemWriteD = 1; ALUSrcD = 1;
        step(0, 0, "sw");
        chk("sw.MemWriteE", 32'(MemWriteE), 32'd1);

        // beq held across a 3-cycle stall while D keeps changing.
        clear_ctrl_d();
        ValidD = 1; BranchD = 1; PCD = 32'h40; PCPlus4D = 32'h44; ZeroE = 1;
        step(0, 0, "beq");
        for (int i = 0; i < 3; i++) begin
            rand_d();
            step(1, 0, "stall");
        end
        chk("stall.PCE", PCE, 32'h40);
        chk("stall.PCSrcE", 32'(PCSrcE), 32'd1);
        step(1, 1, "stall_flush");
        chk("flush.BubbleCnt", 32'(BubbleCnt), 32'd1);

        // Jump select: valid vs invalid slot.
        clear_ctrl_d();
        ZeroE = 0; ValidD = 1; JumpD = 1;
        step(0, 0, "jump_valid");
        chk("jump_valid.PCSrcE", 32'(PCSrcE), 32'd1);
        ValidD = 0;
        step(0, 0, "jump_invalid");
        chk("jump_invalid.PCSrcE", 32'(PCSrcE), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rand_d();
            ZeroE = 1'($urandom);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), "random");
        end

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            rand_d();
            step(1'($urandom), 1, "saturate");
        end
        chk("saturate.BubbleCnt", 32'(BubbleCnt), BMAX);

        // Asynchronous reset between edges.
        clear_ctrl_d();
        ValidD = 1; RegWriteD = 1; RdD = 5'd9;
        step(0, 0, "pre_async");
        chk("pre_async.RegWriteE", 32'(RegWriteE), 32'd1);
        #2;
        rst_n = 1'b0;
        m = '0;
        bexp = 0;
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rand_d();
        step(0, 0, "post_async");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
